// File: rtl/fsm_seq_pkg.sv
// Shared state encoding and default sizing for the fsm_moore burst sequencer.
package fsm_seq_pkg;
  localparam int SYM_W_DEF   = 2;
  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/fsm_seq_symbuf.sv
// Loadable symbol shift register: symbol 0 sits in the low slot, each shift exposes the next one.
module fsm_seq_symbuf #(
  parameter int MAX_LEN = 8,
  parameter int SYM_W   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     load_i,
  input  logic                     shift_i,
  input  logic [MAX_LEN*SYM_W-1:0] syms_i,
  output logic [SYM_W-1:0]         sym_o
);
  logic [MAX_LEN*SYM_W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = syms_i;
    end else if (shift_i) begin
      sh_d = sh_q >> SYM_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign sym_o = sh_q[SYM_W-1:0];
endmodule

// File: rtl/fsm_seq_ctrl.sv
// Burst sequencer for fsm_moore: RST, len DRIVE cycles, DRAIN, DONE; o_done lands len+3 cycles after accept.
// Define FSM_SEQ_HITCNT_EN to add o_hit_cnt, a saturating count of captured 1s.
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int SYM_W   = SYM_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_start,
  input  logic [LEN_W-1:0]         i_len,
  input  logic [MAX_LEN*SYM_W-1:0] i_syms,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [MAX_LEN-1:0]       o_result,
  output logic                     o_err,
  output logic                     o_det_rstn,
  output logic [SYM_W-1:0]         o_det_input,
`ifdef FSM_SEQ_HITCNT_EN
  output logic [LEN_W-1:0]         o_hit_cnt,
`endif
  input  logic                     i_det_output
);
  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d, cnt_q, cnt_d, cap_idx;
  logic [MAX_LEN-1:0]   res_q, res_d;
  logic                 busy_q, done_q, err_q, det_rstn_q;
  logic [SYM_W-1:0]     det_in_q, cur_sym;
  logic                 len_ok, accept, reject, capture;

  assign len_ok  = (i_len != '0) && (i_len <= LEN_W'(MAX_LEN));
  assign accept  = (state_q == ST_IDLE) && i_start && len_ok;
  assign reject  = (state_q == ST_IDLE) && i_start && !len_ok;
  // Moore detector answers one cycle late: the cycle after DRIVE k carries response k.
  assign capture = ((state_q == ST_DRIVE) && (cnt_q != '0)) || (state_q == ST_DRAIN);
  assign cap_idx = (state_q == ST_DRAIN) ? (len_q - LEN_W'(1)) : (cnt_q - LEN_W'(1));

  fsm_seq_symbuf #(.MAX_LEN(MAX_LEN), .SYM_W(SYM_W)) u_symbuf (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (accept),
    .shift_i (state_d == ST_DRIVE),
    .syms_i  (i_syms),
    .sym_o   (cur_sym)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RST;
          len_d   = i_len;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      ST_RST:   state_d = ST_DRIVE;
      ST_DRIVE: begin
        if (cnt_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
        else                             cnt_d   = cnt_q + LEN_W'(1);
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (capture) begin
      res_d = (res_q & ~(MAX_LEN'(1) << cap_idx)) | (MAX_LEN'(i_det_output) << cap_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      det_rstn_q <= 1'b0;
      det_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= reject;
      det_rstn_q <= (state_d == ST_DRIVE) || (state_d == ST_DRAIN);
      det_in_q   <= (state_d == ST_DRIVE) ? cur_sym : '0;
    end
  end

`ifdef FSM_SEQ_HITCNT_EN
  logic [LEN_W-1:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (accept) begin
      hit_d = '0;
    end else if (capture && i_det_output && (hit_q != LEN_W'(MAX_LEN))) begin
      hit_d = hit_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) hit_q <= '0;
    else       hit_q <= hit_d;
  end

  assign o_hit_cnt = hit_q;
`endif

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_result    = res_q;
  assign o_err       = err_q;
  assign o_det_rstn  = det_rstn_q;
  assign o_det_input = det_in_q;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed and random bursts against a cycle-indexed model of the sequencer with a stub detector.
module tb_fsm_seq_ctrl;
  logic        clk = 1'b0;
  logic        rstn, i_start, i_det_output;
  logic [3:0]  i_len;
  logic [15:0] i_syms;
  logic        o_busy, o_done, o_err, o_det_rstn;
  logic [7:0]  o_result;
  logic [1:0]  o_det_input;
`ifdef FSM_SEQ_HITCNT_EN
  logic [3:0]  hit_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fsm_seq_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_syms       (i_syms),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_err        (o_err),
    .o_det_rstn   (o_det_rstn),
    .o_det_input  (o_det_input),
`ifdef FSM_SEQ_HITCNT_EN
    .o_hit_cnt    (hit_cnt),
`endif
    .i_det_output (i_det_output)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [7:0] exp_res);
    check({tag, " busy"}, o_busy, 0);
    check({tag, " done"}, o_done, 0);
    check({tag, " err"}, o_err, 0);
    check({tag, " det_rstn"}, o_det_rstn, 0);
    check({tag, " det_input"}, o_det_input, 0);
    check({tag, " result"}, o_result, exp_res);
  endtask

  // Model: accept edge opens cycle 1; RST is cycle 1, symbol k drives in cycle k+2,
  // its response is whatever the detector shows in cycle k+3, DONE is cycle len+3.
  task automatic burst(input int len, input logic [15:0] syms, input logic [15:0] det, input bit poke);
    logic [7:0] exp_res;
    logic [1:0] exp_sym;
    exp_res = '0;
    for (int k = 0; k < len; k++) exp_res[k] = det[k+3];
    i_len        = 4'(len);
    i_syms       = syms;
    i_start      = 1'b1;
    i_det_output = det[0];
    next_cycle();
    i_start = 1'b0;
    for (int c = 1; c <= len + 3; c++) begin
      exp_sym = (c >= 2 && c <= len + 1) ? syms[2*(c-2) +: 2] : 2'b00;
      check($sformatf("busy len%0d c%0d", len, c), o_busy, 1);
      check($sformatf("done len%0d c%0d", len, c), o_done, (c == len + 3));
      check($sformatf("err len%0d c%0d", len, c), o_err, 0);
      check($sformatf("det_rstn len%0d c%0d", len, c), o_det_rstn, (c >= 2 && c <= len + 2));
      check($sformatf("det_input len%0d c%0d", len, c), o_det_input, exp_sym);
      if (c == len + 3) begin
        check($sformatf("result len%0d", len), o_result, exp_res);
`ifdef FSM_SEQ_HITCNT_EN
        check($sformatf("hit_cnt len%0d", len), hit_cnt, $countones(exp_res));
`endif
      end
      i_det_output = det[c];
      i_start      = poke && (c == 3 || c == len + 3);
      next_cycle();
    end
    i_start = 1'b0;
    check_quiet($sformatf("post len%0d", len), exp_res);
  endtask

  initial begin
    logic [15:0] r_syms, r_det;
    int          r_len;
    bit          done_seen;

    rstn = 1'b0; i_start = 1'b0; i_len = '0; i_syms = '0; i_det_output = 1'b0;
    repeat (2) next_cycle();
    check_quiet("reset", 8'h00);
    rstn = 1'b1;
    next_cycle();

    // Stub responds only in cycle 4, i.e. to symbol 1.
    burst(3, 16'h0034, 16'h0010, 1'b0);
    check("t2 result const", o_result, 8'h02);

    burst(8, 16'hFFFF, 16'hFFFF, 1'b0);
    check("t3 result const", o_result, 8'hFF);

    for (int i = 0; i < 2; i++) begin
      i_len   = (i == 0) ? 4'd0 : 4'd9;
      i_start = 1'b1;
      next_cycle();
      i_start = 1'b0;
      check($sformatf("reject%0d err", i), o_err, 1);
      check($sformatf("reject%0d busy", i), o_busy, 0);
      check($sformatf("reject%0d det_rstn", i), o_det_rstn, 0);
      check($sformatf("reject%0d result", i), o_result, 8'hFF);
      next_cycle();
      check_quiet($sformatf("reject%0d after", i), 8'hFF);
    end

    // Starts during DRIVE and in the DONE cycle are ignored; next burst follows immediately.
    burst(4, 16'h00B1, 16'h5A5A, 1'b1);
    burst(2, 16'h000E, 16'h0028, 1'b0);

    i_len = 4'd5; i_syms = 16'h03E7; i_start = 1'b1; i_det_output = 1'b1;
    next_cycle();
    i_start = 1'b0;
    repeat (2) next_cycle();
    check("midreset in drive", o_det_rstn, 1);
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check_quiet($sformatf("midreset%0d", i), 8'h00);
    end
    rstn = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (o_done || o_busy) done_seen = 1'b1;
    end
    check("midreset no done", done_seen, 0);
    i_det_output = 1'b0;

    for (int n = 0; n < 20; n++) begin
      r_len  = $urandom_range(1, 8);
      r_syms = 16'($urandom);
      r_det  = 16'($urandom);
      burst(r_len, r_syms, r_det, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
